// File: rtl/cpu_wb_master.sv
// rtl/cpu_wb_master.sv - CPU memory port to Wishbone classic single-cycle master bridge
module cpu_wb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        err_o,

    input  logic [5:0]  stall_i,
    input  logic        flush_i,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [31:0] rd_buf;
    logic [31:0] rd_buf_nxt;
    logic        err_nxt;

    logic [31:0] adr_nxt;
    logic [31:0] dat_nxt;
    logic        we_nxt;
    logic [3:0]  sel_nxt;
    logic        stb_nxt;
    logic        cyc_nxt;

    logic        start_req;
    logic        pipe_held;
    logic        terminal;

    assign start_req = cpu_ce_i & ~flush_i;
    assign pipe_held = |stall_i;
    assign terminal  = (cnt == CNT_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            rd_buf   <= 32'd0;
            err_o    <= 1'b0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'd0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_buf   <= rd_buf_nxt;
            err_o    <= err_nxt;
            wb_adr_o <= adr_nxt;
            wb_dat_o <= dat_nxt;
            wb_we_o  <= we_nxt;
            wb_sel_o <= sel_nxt;
            wb_stb_o <= stb_nxt;
            wb_cyc_o <= cyc_nxt;
        end
    end

    // Wishbone outputs are registered; any termination returns the whole bus to zero.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rd_buf_nxt = rd_buf;
        err_nxt    = 1'b0;
        adr_nxt    = wb_adr_o;
        dat_nxt    = wb_dat_o;
        we_nxt     = wb_we_o;
        sel_nxt    = wb_sel_o;
        stb_nxt    = wb_stb_o;
        cyc_nxt    = wb_cyc_o;

        case (state)
            IDLE: begin
                if (start_req) begin
                    adr_nxt   = cpu_addr_i;
                    dat_nxt   = cpu_data_i;
                    we_nxt    = cpu_we_i;
                    sel_nxt   = cpu_sel_i;
                    stb_nxt   = 1'b1;
                    cyc_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = BUSY;
                end else begin
                    adr_nxt = 32'd0;
                    dat_nxt = 32'd0;
                    we_nxt  = 1'b0;
                    sel_nxt = 4'd0;
                    stb_nxt = 1'b0;
                    cyc_nxt = 1'b0;
                end
            end

            BUSY: begin
                if (flush_i || wb_ack_i || terminal) begin
                    adr_nxt = 32'd0;
                    dat_nxt = 32'd0;
                    we_nxt  = 1'b0;
                    sel_nxt = 4'd0;
                    stb_nxt = 1'b0;
                    cyc_nxt = 1'b0;
                end

                // Priority: flush discards, then ack, then the timeout.
                if (flush_i) begin
                    rd_buf_nxt = 32'd0;
                    state_nxt  = IDLE;
                end else if (wb_ack_i) begin
                    rd_buf_nxt = wb_we_o ? 32'd0 : wb_dat_i;
                    state_nxt  = pipe_held ? HOLD : IDLE;
                end else if (terminal) begin
                    rd_buf_nxt = 32'd0;
                    err_nxt    = 1'b1;
                    state_nxt  = pipe_held ? HOLD : IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            HOLD: begin
                if (flush_i) begin
                    rd_buf_nxt = 32'd0;
                    state_nxt  = IDLE;
                end else if (!pipe_held) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;

        case (state)
            IDLE: begin
                stallreq_o = start_req;
            end
            BUSY: begin
                stallreq_o = ~flush_i & ~wb_ack_i & ~terminal;
                if (wb_ack_i && !wb_we_o && !flush_i) begin
                    cpu_data_o = wb_dat_i;
                end
            end
            HOLD: begin
                cpu_data_o = rd_buf;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_wb_master.sv
// tb/tb_cpu_wb_master.sv - scoreboard bench for cpu_wb_master with directed vectors
module tb_cpu_wb_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        err_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    cpu_wb_master #(.TIMEOUT(4)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(input logic [31:0] adr, input logic [31:0] dat,
                                    input logic we, input logic [3:0] sel);
        req_t r;
        r.adr = adr;
        r.dat = dat;
        r.we  = we;
        r.sel = sel;
        return r;
    endfunction

    function automatic rsp_t mk_rsp(input logic [31:0] data, input logic err);
        rsp_t r;
        r.data = data;
        r.err  = err;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic settle();
        @(negedge wb_clk_i);
    endtask

    task automatic issue(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, input logic [31:0] rdata, input logic err);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = adr;
        cpu_data_i = dat;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        req_q.push_back(mk_req(adr, dat, we, sel));
        rsp_q.push_back(mk_rsp(rdata, err));
    endtask

    // Monitor: one Wishbone request per stb rising edge, one response per stallreq falling edge.
    initial begin : monitor
        logic prev_stb;
        logic prev_stall;
        logic err_pending;
        logic err_exp;
        req_t r;
        rsp_t s;
        prev_stb    = 1'b0;
        prev_stall  = 1'b0;
        err_pending = 1'b0;
        err_exp     = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (err_pending) begin
                chk("err_o after return", err_o, err_exp);
                err_pending = 1'b0;
            end else if (err_o) begin
                chk("spurious err_o", err_o, 0);
            end
            if (wb_stb_o && !prev_stb) begin
                if (req_q.size() == 0) begin
                    chk("unexpected wb cycle", wb_stb_o, 0);
                end else begin
                    r = req_q.pop_front();
                    chk("wb_adr_o", wb_adr_o, r.adr);
                    chk("wb_dat_o", wb_dat_o, r.dat);
                    chk("wb_we_o", wb_we_o, r.we);
                    chk("wb_sel_o", wb_sel_o, r.sel);
                    chk("wb_cyc_o", wb_cyc_o, 1);
                end
            end
            if (prev_stall && !stallreq_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected return", 32'(prev_stall), 0);
                end else begin
                    s = rsp_q.pop_front();
                    chk("cpu_data_o on return", cpu_data_o, s.data);
                    err_pending = 1'b1;
                    err_exp     = s.err;
                end
            end
            prev_stb   = wb_stb_o;
            prev_stall = stallreq_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        wb_rst_i   = 1'b1;
        cpu_ce_i   = 1'b0;
        cpu_addr_i = 32'd0;
        cpu_data_i = 32'd0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'd0;
        stall_i    = 6'd0;
        flush_i    = 1'b0;
        wb_dat_i   = 32'd0;
        wb_ack_i   = 1'b0;

        next_cycle();
        next_cycle();
        wb_rst_i = 1'b0;
        settle();
        chk("reset stb", wb_stb_o, 0);
        chk("reset cyc", wb_cyc_o, 0);
        chk("reset we", wb_we_o, 0);
        chk("reset sel", wb_sel_o, 0);
        chk("reset adr", wb_adr_o, 0);
        chk("reset err", err_o, 0);
        chk("reset stallreq", stallreq_o, 0);
        chk("reset cpu_data", cpu_data_o, 0);

        // 1: load, zero-wait slave
        next_cycle();
        issue(32'h0000_0010, 32'd0, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0);
        settle();
        chk("t1 stallreq T", stallreq_o, 1);
        chk("t1 stb T", wb_stb_o, 0);
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
        settle();
        chk("t1 adr T+1", wb_adr_o, 32'h10);
        chk("t1 stb T+1", wb_stb_o, 1);
        chk("t1 stallreq T+1", stallreq_o, 0);
        chk("t1 data T+1", cpu_data_o, 32'hDEADBEEF);
        next_cycle();
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'd0;
        settle();
        chk("t1 stb T+2", wb_stb_o, 0);
        chk("t1 cyc T+2", wb_cyc_o, 0);

        // 2: store, 3 wait states; ack lands on the terminal count and must win
        next_cycle();
        issue(32'h0000_0020, 32'h12345678, 1'b1, 4'h3, 32'd0, 1'b0);
        settle();
        chk("t2 stallreq T", stallreq_o, 1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            cpu_data_i = 32'hA5A5_0000 + i;
            cpu_addr_i = 32'h0000_0F00;
            wb_ack_i   = (i == 4);
            wb_dat_i   = (i == 4) ? 32'hFFFF_FFFF : 32'd0;
            settle();
            chk("t2 we", wb_we_o, 1);
            chk("t2 sel", wb_sel_o, 4'h3);
            chk("t2 dat", wb_dat_o, 32'h12345678);
            chk("t2 adr", wb_adr_o, 32'h20);
            chk("t2 stallreq", stallreq_o, (i < 4) ? 1 : 0);
            chk("t2 cpu_data", cpu_data_o, 0);
        end
        next_cycle();
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'd0;
        settle();
        chk("t2 stb after", wb_stb_o, 0);
        chk("t2 rd_buf cleared by store", dut.rd_buf, 0);

        // 3: load ack while pipeline held, data buffered in HOLD
        next_cycle();
        issue(32'h0000_0030, 32'd0, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0);
        stall_i = 6'h03;
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFEF00D;
        settle();
        chk("t3 bypass", cpu_data_o, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            cpu_ce_i = 1'b0;
            wb_ack_i = 1'b0;
            wb_dat_i = 32'h1111_2222;
            stall_i  = (i == 2) ? 6'd0 : 6'h03;
            settle();
            chk("t3 hold data", cpu_data_o, 32'hCAFEF00D);
            chk("t3 hold stb", wb_stb_o, 0);
            chk("t3 hold stallreq", stallreq_o, 0);
        end
        next_cycle();
        wb_dat_i = 32'd0;
        settle();
        chk("t3 data after hold", cpu_data_o, 0);
        chk("t3 no second cycle", wb_stb_o, 0);

        // 4: flush coincident with ack
        next_cycle();
        issue(32'h0000_0040, 32'd0, 1'b0, 4'hF, 32'd0, 1'b0);
        next_cycle();
        wb_ack_i = 1'b1;
        flush_i  = 1'b1;
        wb_dat_i = 32'h55AA55AA;
        settle();
        chk("t4 stallreq", stallreq_o, 0);
        next_cycle();
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        flush_i  = 1'b0;
        wb_dat_i = 32'd0;
        settle();
        chk("t4 stb", wb_stb_o, 0);
        chk("t4 cyc", wb_cyc_o, 0);
        chk("t4 err", err_o, 0);
        chk("t4 rd_buf", dut.rd_buf, 0);

        // 5: timeout with TIMEOUT=4
        next_cycle();
        issue(32'h0000_0050, 32'd0, 1'b0, 4'hF, 32'd0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            settle();
            chk("t5 stb", wb_stb_o, 1);
            chk("t5 stallreq", stallreq_o, (i < 4) ? 1 : 0);
            chk("t5 cpu_data", cpu_data_o, 0);
        end
        next_cycle();
        cpu_ce_i = 1'b0;
        settle();
        chk("t5 stb after", wb_stb_o, 0);
        chk("t5 err pulse", err_o, 1);
        next_cycle();
        settle();
        chk("t5 err cleared", err_o, 0);

        // 6: reset mid-BUSY, then a normal access
        next_cycle();
        issue(32'h0000_0060, 32'h0BAD_CAFE, 1'b1, 4'hC, 32'd0, 1'b0);
        next_cycle();
        wb_rst_i = 1'b1;
        settle();
        chk("t6 stb busy", wb_stb_o, 1);
        next_cycle();
        wb_rst_i = 1'b0;
        cpu_ce_i = 1'b0;
        settle();
        chk("t6 stb", wb_stb_o, 0);
        chk("t6 cyc", wb_cyc_o, 0);
        chk("t6 we", wb_we_o, 0);
        chk("t6 sel", wb_sel_o, 0);
        chk("t6 adr", wb_adr_o, 0);
        chk("t6 dat", wb_dat_o, 0);
        chk("t6 stallreq", stallreq_o, 0);
        next_cycle();
        issue(32'h0000_0070, 32'd0, 1'b0, 4'hF, 32'h0BADF00D, 1'b0);
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BADF00D;
        settle();
        chk("t6 data", cpu_data_o, 32'h0BADF00D);
        next_cycle();
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'd0;
        settle();
        chk("t6 stb after", wb_stb_o, 0);

        next_cycle();
        next_cycle();
        settle();
        chk("req queue drained", req_q.size(), 0);
        chk("rsp queue drained", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
